// File: rtl/psr_file_if.sv
// Bus bundle for the program status register file.
// Requester side (master) drives pipeline advance, flag/T writeback, MSR,
// exception entry and exception return requests, and observes the status
// outputs. The register file (slave) samples requests and presents
// cpsr, spsr, mode and priv.
//
// Handshake: there is no valid/ready pair. Each request strobe
// (flag_we, t_we, msr_we, exc_take, ret_we) is a single-cycle command that
// is consumed on the rising clock edge when en is high. It is never
// back-pressured and has no acknowledge.
interface psr_file_if;
    logic        en;
    logic [3:0]  flag_we;
    logic [3:0]  flag_in;
    logic        t_we;
    logic        t_in;
    logic        msr_we;
    logic        msr_spsr;
    logic [3:0]  msr_fields;
    logic [31:0] msr_data;
    logic        exc_take;
    logic [2:0]  exc_type;
    logic        ret_we;
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic [4:0]  mode;
    logic        priv;

    modport master (
        output en, flag_we, flag_in, t_we, t_in, msr_we, msr_spsr,
               msr_fields, msr_data, exc_take, exc_type, ret_we,
        input  cpsr, spsr, mode, priv
    );

    modport slave (
        input  en, flag_we, flag_in, t_we, t_in, msr_we, msr_spsr,
               msr_fields, msr_data, exc_take, exc_type, ret_we,
        output cpsr, spsr, mode, priv
    );
endinterface

// File: rtl/psr_file.sv
// ARM7TDMI program status register file: CPSR plus banked SPSRs for
// FIQ, IRQ, SVC, ABT and UND.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (overrides bus.en)
//   bus  - psr_file_if.slave: update requests in, cpsr/spsr/mode/priv out
// One update source per cycle, priority:
//   exc_take > ret_we > msr_we > (flag_we | t_we)
// Bits [27:8] of every status register are held at zero.
module psr_file #(
    parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
    input logic        clk,
    input logic        rst,
    psr_file_if.slave  bus
);
    localparam logic [31:0] PSR_MASK = 32'hF000_00FF;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    // Banked SPSR slot numbers; SLOT_NONE marks modes without an SPSR.
    localparam logic [2:0] SLOT_FIQ  = 3'd0;
    localparam logic [2:0] SLOT_IRQ  = 3'd1;
    localparam logic [2:0] SLOT_SVC  = 3'd2;
    localparam logic [2:0] SLOT_ABT  = 3'd3;
    localparam logic [2:0] SLOT_UND  = 3'd4;
    localparam logic [2:0] SLOT_NONE = 3'd7;

    logic [31:0] cpsr_q, cpsr_d;
    logic [31:0] spsr_q [5];
    logic [31:0] spsr_d [5];

    logic [2:0]  cur_slot;
    logic        has_spsr;
    logic [31:0] spsr_cur;
    logic [2:0]  exc_slot;
    logic [4:0]  exc_mode;

    function automatic logic [2:0] spsr_slot(input logic [4:0] m);
        case (m)
            MODE_FIQ: spsr_slot = SLOT_FIQ;
            MODE_IRQ: spsr_slot = SLOT_IRQ;
            MODE_SVC: spsr_slot = SLOT_SVC;
            MODE_ABT: spsr_slot = SLOT_ABT;
            MODE_UND: spsr_slot = SLOT_UND;
            default:  spsr_slot = SLOT_NONE;
        endcase
    endfunction

    function automatic logic valid_mode(input logic [4:0] m);
        case (m)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: valid_mode = 1'b1;
            default:                      valid_mode = 1'b0;
        endcase
    endfunction

    // USR, SYS and any unvalidated mode restored from an SPSR have no
    // bank; in those modes spsr mirrors cpsr.
    assign cur_slot = spsr_slot(cpsr_q[4:0]);
    assign has_spsr = (cur_slot != SLOT_NONE);

    always_comb begin
        spsr_cur = cpsr_q;
        case (cur_slot)
            SLOT_FIQ: spsr_cur = spsr_q[0];
            SLOT_IRQ: spsr_cur = spsr_q[1];
            SLOT_SVC: spsr_cur = spsr_q[2];
            SLOT_ABT: spsr_cur = spsr_q[3];
            SLOT_UND: spsr_cur = spsr_q[4];
            default:  spsr_cur = cpsr_q;
        endcase
    end

    always_comb begin
        exc_mode = MODE_SVC;
        exc_slot = SLOT_SVC;
        case (bus.exc_type)
            3'd0, 3'd2: begin exc_mode = MODE_SVC; exc_slot = SLOT_SVC; end
            3'd1:       begin exc_mode = MODE_UND; exc_slot = SLOT_UND; end
            3'd3, 3'd4: begin exc_mode = MODE_ABT; exc_slot = SLOT_ABT; end
            3'd5:       begin exc_mode = MODE_IRQ; exc_slot = SLOT_IRQ; end
            3'd6:       begin exc_mode = MODE_FIQ; exc_slot = SLOT_FIQ; end
            default:    begin exc_mode = MODE_SVC; exc_slot = SLOT_SVC; end
        endcase
    end

    always_comb begin
        cpsr_d = cpsr_q;
        for (int i = 0; i < 5; i++) spsr_d[i] = spsr_q[i];

        if (bus.exc_take) begin
            // Reserved type 7 still claims the cycle but changes nothing.
            if (bus.exc_type != 3'd7) begin
                spsr_d[exc_slot] = cpsr_q;
                cpsr_d[4:0]      = exc_mode;
                cpsr_d[7]        = 1'b1;
                cpsr_d[5]        = 1'b0;
                if (bus.exc_type == 3'd0 || bus.exc_type == 3'd6)
                    cpsr_d[6] = 1'b1;
            end
        end else if (bus.ret_we) begin
            if (has_spsr) cpsr_d = spsr_cur;
        end else if (bus.msr_we) begin
            if (bus.msr_spsr) begin
                // SPSR writes are verbatim, so T and an odd mode can land here.
                if (has_spsr) begin
                    if (bus.msr_fields[3]) spsr_d[cur_slot][31:28] = bus.msr_data[31:28];
                    if (bus.msr_fields[0]) spsr_d[cur_slot][7:0]   = bus.msr_data[7:0];
                end
            end else begin
                if (bus.msr_fields[3]) cpsr_d[31:28] = bus.msr_data[31:28];
                // T (bit 5) is never written through MSR to CPSR.
                if (bus.msr_fields[0] && cpsr_q[4:0] != MODE_USR &&
                    valid_mode(bus.msr_data[4:0])) begin
                    cpsr_d[7:6] = bus.msr_data[7:6];
                    cpsr_d[4:0] = bus.msr_data[4:0];
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.flag_we[i]) cpsr_d[28+i] = bus.flag_in[i];
            end
            if (bus.t_we) cpsr_d[5] = bus.t_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpsr_q <= RESET_CPSR & PSR_MASK;
            for (int i = 0; i < 5; i++) spsr_q[i] <= 32'h0;
        end else if (bus.en) begin
            cpsr_q <= cpsr_d & PSR_MASK;
            for (int i = 0; i < 5; i++) spsr_q[i] <= spsr_d[i] & PSR_MASK;
        end
    end

    assign bus.cpsr = cpsr_q;
    assign bus.spsr = spsr_cur;
    assign bus.mode = cpsr_q[4:0];
    assign bus.priv = (cpsr_q[4:0] != MODE_USR);
endmodule

// File: tb/tb_psr_file.sv
module tb_psr_file;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    psr_file_if bus ();

    psr_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        bus.en         = 1'b1;
        bus.flag_we    = 4'b0;
        bus.flag_in    = 4'b0;
        bus.t_we       = 1'b0;
        bus.t_in       = 1'b0;
        bus.msr_we     = 1'b0;
        bus.msr_spsr   = 1'b0;
        bus.msr_fields = 4'b0;
        bus.msr_data   = 32'h0;
        bus.exc_take   = 1'b0;
        bus.exc_type   = 3'd0;
        bus.ret_we     = 1'b0;
        rst            = 1'b0;
    endtask

    // Apply the currently driven inputs for one edge, then return to idle.
    // Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    task automatic do_flags(input logic [3:0] we, input logic [3:0] val);
        bus.flag_we = we;
        bus.flag_in = val;
        step();
    endtask

    task automatic do_t(input logic val);
        bus.t_we = 1'b1;
        bus.t_in = val;
        step();
    endtask

    task automatic do_msr(input logic to_spsr, input logic [3:0] fields, input logic [31:0] data);
        bus.msr_we     = 1'b1;
        bus.msr_spsr   = to_spsr;
        bus.msr_fields = fields;
        bus.msr_data   = data;
        step();
    endtask

    task automatic do_exc(input logic [2:0] ty);
        bus.exc_take = 1'b1;
        bus.exc_type = ty;
        step();
    endtask

    task automatic do_ret();
        bus.ret_we = 1'b1;
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle();

        // Reset state
        check("rst_cpsr", bus.cpsr, 32'h0000_00D3);
        check("rst_spsr", bus.spsr, 32'h0);
        check("rst_mode", {27'b0, bus.mode}, 32'h13);
        check("rst_priv", {31'b0, bus.priv}, 32'h1);

        // Partial flag write: only Z and C
        do_flags(4'b0110, 4'b1111);
        check("flags_zc", bus.cpsr, 32'h6000_00D3);

        // Drop to USR with I=F=0
        do_msr(1'b0, 4'b0001, 32'h0000_0010);
        check("msr_to_usr", bus.cpsr, 32'h6000_0010);
        check("usr_priv", {31'b0, bus.priv}, 32'h0);
        check("usr_spsr_mirror", bus.spsr, 32'h6000_0010);

        // IRQ entry and return
        do_exc(3'd5);
        check("irq_cpsr", bus.cpsr, 32'h6000_0092);
        check("irq_spsr", bus.spsr, 32'h6000_0010);
        do_ret();
        check("irq_ret_cpsr", bus.cpsr, 32'h6000_0010);
        check("irq_ret_priv", {31'b0, bus.priv}, 32'h0);

        // Return in USR has no effect
        do_ret();
        check("usr_ret_noop", bus.cpsr, 32'h6000_0010);

        // FIQ entry clears T, sets F and I
        do_reset();
        do_t(1'b1);
        check("t_set", bus.cpsr, 32'h0000_00F3);
        do_exc(3'd6);
        check("fiq_cpsr", bus.cpsr, 32'h0000_00D1);
        check("fiq_spsr", bus.spsr, 32'h0000_00F3);

        // USR MSR: c byte ignored, f byte applied, bits [27:24] dropped
        do_msr(1'b0, 4'b0001, 32'h0000_0010);
        check("fiq_to_usr", bus.cpsr, 32'h0000_0010);
        do_msr(1'b0, 4'b1001, 32'hF000_00D3);
        check("usr_msr", bus.cpsr, 32'hF000_0010);

        // SWI entry: F unchanged (0)
        do_exc(3'd2);
        check("swi_cpsr", bus.cpsr, 32'hF000_0093);
        check("swi_spsr", bus.spsr, 32'hF000_0010);

        // Invalid mode drops the whole control byte
        do_msr(1'b0, 4'b0001, 32'h0000_0005);
        check("bad_mode_c", bus.cpsr, 32'hF000_0093);
        do_msr(1'b0, 4'b1001, 32'h0000_00C5);
        check("bad_mode_fc", bus.cpsr, 32'h0000_0093);

        // MSR to SPSR: verbatim f/c bytes, middle bits dropped
        do_msr(1'b1, 4'b1001, 32'hABCD_EF3F);
        check("msr_spsr", bus.spsr, 32'hA000_003F);
        check("msr_spsr_cpsr", bus.cpsr, 32'h0000_0093);

        // Return into SYS with T=1
        do_ret();
        check("ret_sys_cpsr", bus.cpsr, 32'hA000_003F);
        check("sys_mode", {27'b0, bus.mode}, 32'h1F);
        check("sys_priv", {31'b0, bus.priv}, 32'h1);
        do_ret();
        check("sys_ret_noop", bus.cpsr, 32'hA000_003F);

        // Contention: entry wins over MSR and flags
        bus.exc_take   = 1'b1;
        bus.exc_type   = 3'd5;
        bus.msr_we     = 1'b1;
        bus.msr_fields = 4'b1000;
        bus.msr_data   = 32'h0;
        bus.flag_we    = 4'b1111;
        bus.flag_in    = 4'b0000;
        step();
        check("contend_cpsr", bus.cpsr, 32'hA000_0092);
        check("contend_spsr", bus.spsr, 32'hA000_003F);

        // Return wins over MSR
        bus.ret_we     = 1'b1;
        bus.msr_we     = 1'b1;
        bus.msr_fields = 4'b1000;
        bus.msr_data   = 32'h5000_0000;
        step();
        check("ret_over_msr", bus.cpsr, 32'hA000_003F);

        // en=0 blocks exception entry
        bus.en       = 1'b0;
        bus.exc_take = 1'b1;
        bus.exc_type = 3'd6;
        step();
        check("en0_cpsr", bus.cpsr, 32'hA000_003F);

        // Reserved exception type does nothing
        do_exc(3'd7);
        check("exc7_cpsr", bus.cpsr, 32'hA000_003F);

        // Reset overrides en=0 and clears SPSRs
        bus.en = 1'b0;
        rst    = 1'b1;
        step();
        check("rst_en0_cpsr", bus.cpsr, 32'h0000_00D3);
        check("rst_en0_spsr", bus.spsr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
